sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//   Single-clock first-in/first-out buffer for byte-wide data between a producer and a consumer
//   running on the same clock. Writes and reads are enable-qualified. full/empty flags provide
//   back-pressure. Sits as a generic elasticity buffer in datapaths.
// PARAMETERS
//   DATA_WIDTH  8  width of data_in/data_out in bits
//   DEPTH       8  number of storage entries; power of two, >= 2
//   ADDR_WIDTH  3  log2(DEPTH); pointer index width (pointers carry one extra wrap bit)
// PORTS
//   clk       in   1           single clock; all state updates on rising edge
//   rst       in   1           reset, synchronous, active-high
//   w_en      in   1           write request; data_in captured when w_en=1 and full=0
//   r_en      in   1           read request; oldest entry popped when r_en=1 and empty=0
//   data_in   in   DATA_WIDTH  write data
//   data_out  out  DATA_WIDTH  read data, registered
//   full      out  1           1 when DEPTH entries held
//   empty     out  1           1 when 0 entries held
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
//   - Reset values:
//     - wr_ptr=0, rd_ptr=0.
//     - data_out=0, empty=1, full=0.
//     - Memory contents are not cleared.
//   - Pointers are ADDR_WIDTH+1 bits. Index = low ADDR_WIDTH bits; MSB = wrap bit.
//   - Flags are combinational from the registered pointers:
//     - empty = (wr_ptr == rd_ptr).
//     - full = index bits equal AND wrap bits differ.
//   - Write accept (wr_ok = w_en & ~full):
//     - On the edge, mem[wr_ptr idx] <= data_in.
//     - wr_ptr increments modulo 2*DEPTH.
//   - Read accept (rd_ok = r_en & ~empty):
//     - On the edge, data_out <= mem[rd_ptr idx].
//     - rd_ptr increments.
//     - Latency: data_out is valid after the same edge that accepts the read, i.e. one cycle
//       after r_en is driven.
//   - data_out holds its last value when no read is accepted, including reads while empty.
//   - Write while full: dropped. No pointer or memory change. No error output.
//   - Read while empty: ignored. Pointers and data_out are unchanged.
//   - Simultaneous w_en & r_en: each is qualified independently by the pre-edge flags.
//     - Neither full nor empty: both are performed; occupancy is unchanged.
//     - When empty: only the write is performed. No write-through to data_out; the new data is
//       readable on a later cycle.
//     - When full: only the read is performed. The write is dropped.
//   - Wrap-around: index wraps DEPTH-1 -> 0 and the wrap bit toggles. Ordering is preserved
//     across wrap.
//   - Reset mid-operation: on the reset edge, all queued data is discarded, flags return to
//     empty=1/full=0, and data_out=0. Any w_en/r_en present in the reset cycle is ignored.
//   - No X on outputs after the first reset edge.
// TESTING
//   1. Reset: rst=1 for 1+ edges -> empty=1, full=0, data_out=0.
//   2. Basic order: write 10,20,30,40 on consecutive edges, idle, then r_en=1 for 4 edges ->
//      data_out 10,20,30,40 on successive edges; empty=1 after the 4th read; data_out holds 40.
//   3. Full: write 8 values 1..8 -> full=1 after the 8th; a 9th write (99) is dropped; read all
//      -> 1..8, 99 never appears.
//   4. Underflow: r_en=1 while empty -> data_out unchanged, empty stays 1, pointers unchanged.
//   5. Simultaneous: with 3 entries, w_en&r_en for 5 edges -> occupancy stays 3, FIFO order is
//      kept; with full=1, w_en&r_en -> 1 pop and write dropped, full=0.
//   6. Wrap/reset: 20 writes interleaved with reads keep order across wrap; assert rst with
//      2 entries held -> empty=1, data_out=0 next cycle.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data and full/empty flags derived from
// wrap-bit pointers. Reset is synchronous, active-high; storage is not cleared on reset.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ok, rd_ok;

  // Equal indices: same wrap bit means empty, differing wrap bit means full.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
            (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    wr_ok = w_en & ~full;
    rd_ok = r_en & ~empty;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      data_out_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage has no reset; writes are simply suppressed during the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: ordering, full/empty boundaries,
// simultaneous access, wrap-around and mid-operation reset.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (8),
    .ADDR_WIDTH(3)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .w_en    (w_en),
    .r_en    (r_en),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    w_en    = 1'b1;
    r_en    = 1'b0;
    data_in = v;
    tick();
    idle();
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] v);
    w_en = 1'b0;
    r_en = 1'b1;
    tick();
    idle();
    check_eq(tag, {24'd0, data_out}, {24'd0, v});
  endtask

  initial begin
    rst     = 1'b1;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'd0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_dout", {24'd0, data_out}, 32'd0);

    // Basic order
    push(8'd10);
    check_eq("order_not_empty", {31'd0, empty}, 32'd0);
    push(8'd20);
    push(8'd30);
    push(8'd40);
    tick();
    pop_expect("order_rd0", 8'd10);
    pop_expect("order_rd1", 8'd20);
    pop_expect("order_rd2", 8'd30);
    pop_expect("order_rd3", 8'd40);
    check_eq("order_empty", {31'd0, empty}, 32'd1);
    tick();
    check_eq("order_hold", {24'd0, data_out}, 32'd40);

    // Underflow: reads while empty change nothing
    r_en = 1'b1;
    tick();
    tick();
    idle();
    check_eq("uflow_dout", {24'd0, data_out}, 32'd40);
    check_eq("uflow_empty", {31'd0, empty}, 32'd1);
    push(8'd55);
    pop_expect("uflow_ptrs", 8'd55);
    check_eq("uflow_empty2", {31'd0, empty}, 32'd1);

    // Full
    for (int i = 1; i <= 8; i++) begin
      push(i[7:0]);
      if (i == 7) check_eq("full_at7", {31'd0, full}, 32'd0);
    end
    check_eq("full_at8", {31'd0, full}, 32'd1);
    push(8'd99);
    check_eq("full_drop", {31'd0, full}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      pop_expect($sformatf("full_rd%0d", i), i[7:0]);
    end
    check_eq("full_drained", {31'd0, empty}, 32'd1);
    pop_expect("full_no99", 8'd8);

    // Simultaneous with 3 entries held
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    begin
      logic [7:0] exp_q[$];
      exp_q = '{8'hA1, 8'hA2, 8'hA3};
      for (int i = 1; i <= 5; i++) begin
        w_en    = 1'b1;
        r_en    = 1'b1;
        data_in = 8'hB0 + i[7:0];
        exp_q.push_back(data_in);
        tick();
        check_eq($sformatf("simul_rd%0d", i), {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        check_eq($sformatf("simul_empty%0d", i), {31'd0, empty}, 32'd0);
        check_eq($sformatf("simul_full%0d", i), {31'd0, full}, 32'd0);
      end
      idle();
    end
    pop_expect("simul_tail0", 8'hB3);
    pop_expect("simul_tail1", 8'hB4);
    pop_expect("simul_tail2", 8'hB5);
    check_eq("simul_empty", {31'd0, empty}, 32'd1);

    // Simultaneous while full: only the read happens
    for (int i = 0; i < 8; i++) push(8'h60 + i[7:0]);
    check_eq("sf_full", {31'd0, full}, 32'd1);
    w_en    = 1'b1;
    r_en    = 1'b1;
    data_in = 8'hEE;
    tick();
    idle();
    check_eq("sf_dout", {24'd0, data_out}, 32'h60);
    check_eq("sf_not_full", {31'd0, full}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      pop_expect($sformatf("sf_rd%0d", i), 8'h60 + i[7:0]);
    end
    check_eq("sf_empty", {31'd0, empty}, 32'd1);

    // Simultaneous while empty: write only, no write-through
    w_en    = 1'b1;
    r_en    = 1'b1;
    data_in = 8'h3C;
    tick();
    idle();
    check_eq("se_dout", {24'd0, data_out}, 32'h67);
    check_eq("se_not_empty", {31'd0, empty}, 32'd0);
    pop_expect("se_rd", 8'h3C);

    // Wrap: 20 writes with two entries in flight
    push(8'd100);
    push(8'd101);
    for (int i = 2; i < 20; i++) begin
      w_en    = 1'b1;
      r_en    = 1'b1;
      data_in = 8'd100 + i[7:0];
      tick();
      check_eq($sformatf("wrap_rd%0d", i - 2), {24'd0, data_out}, 32'd98 + i);
    end
    idle();

    // Reset with 2 entries held and both enables active
    rst     = 1'b1;
    w_en    = 1'b1;
    r_en    = 1'b1;
    data_in = 8'h77;
    tick();
    rst = 1'b0;
    idle();
    check_eq("mrst_empty", {31'd0, empty}, 32'd1);
    check_eq("mrst_full", {31'd0, full}, 32'd0);
    check_eq("mrst_dout", {24'd0, data_out}, 32'd0);
    pop_expect("mrst_uflow", 8'd0);
    check_eq("mrst_still_empty", {31'd0, empty}, 32'd1);
    push(8'd7);
    pop_expect("mrst_after", 8'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
